// File: rtl/score_display_driver_if.sv
// Score display bus: load strobe and binary value in, conversion status and
// active-low segment outputs back.
interface score_display_driver_if #(
    parameter int BIN_WIDTH  = 16,
    parameter int NUM_DIGITS = 6
);
    logic                      load;
    logic [BIN_WIDTH-1:0]      value;
    logic                      busy;
    logic                      done;
    logic                      overflow;
    logic [7*NUM_DIGITS-1:0]   leds;

    modport master (output load, value, input busy, done, overflow, leds);
    modport slave  (input load, value, output busy, done, overflow, leds);
endinterface

// File: rtl/score_display_driver.sv
// Multi-digit seven-segment score driver: binary to BCD via a sequential
// shift-add-3 engine, then overflow dashes, optional leading-zero blanking
// and active-low segment decode.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for load; outputs hold the last result
// ST_CONVERT | one add-3/shift step per cycle, BIN_WIDTH cycles
// ST_UPDATE  | new leds/overflow visible, done high, busy still high
module score_display_driver #(
    parameter int BIN_WIDTH     = 16,
    parameter int NUM_DIGITS    = 6,
    parameter int BLANK_LEADING = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    score_display_driver_if.slave bus
);
    // Enough BCD digits for any BIN_WIDTH value, and never fewer than shown.
    localparam int INT_CALC   = (BIN_WIDTH * 3) / 10 + 1;
    localparam int INT_DIGITS = (NUM_DIGITS > INT_CALC) ? NUM_DIGITS : INT_CALC;
    localparam int BCD_W      = 4 * INT_DIGITS;
    localparam int LED_W      = 7 * NUM_DIGITS;
    localparam int CNT_W      = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_UPDATE  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [BIN_WIDTH-1:0]     r_bin;
    logic [BCD_W-1:0]         r_bcd;
    logic [CNT_W-1:0]         r_cnt;
    logic [LED_W-1:0]         r_leds;
    logic                     r_overflow;
    logic                     r_done;
    logic                     r_busy;

    logic [BCD_W-1:0]         w_bcd_adj;
    logic [BCD_W+BIN_WIDTH-1:0] w_shift;
    logic [BCD_W-1:0]         w_bcd_next;
    logic [BIN_WIDTH-1:0]     w_bin_next;
    logic                     w_cnt_tc;
    logic                     w_ovf;
    logic [LED_W-1:0]         w_leds;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // One double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin}.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < INT_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
        w_shift    = {w_bcd_adj, r_bin} << 1;
        w_bcd_next = w_shift[BCD_W+BIN_WIDTH-1 : BIN_WIDTH];
        w_bin_next = w_shift[BIN_WIDTH-1:0];
    end

    assign w_cnt_tc = (r_cnt == '0);

    // Display image of the post-step BCD value, so it can be latched on the
    // final conversion edge without an extra pipeline stage.
    always_comb begin
        logic       v_lead;
        logic [3:0] v_digit;
        w_ovf   = 1'b0;
        w_leds  = '1;
        v_lead  = 1'b1;
        v_digit = 4'd0;
        for (int i = NUM_DIGITS; i < INT_DIGITS; i++)
            w_ovf = w_ovf | (|w_bcd_next[4*i +: 4]);
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            v_digit = w_bcd_next[4*k +: 4];
            v_lead  = v_lead & (v_digit == 4'd0);
            if (w_ovf)
                w_leds[7*k +: 7] = SEG_DASH;
            else if ((BLANK_LEADING != 0) && (k != 0) && v_lead)
                w_leds[7*k +: 7] = SEG_BLANK;
            else
                w_leds[7*k +: 7] = seg7(v_digit);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    // Next-state logic; load is only honoured from idle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:    if (bus.load) w_state_next = ST_CONVERT;
            ST_CONVERT: if (w_cnt_tc) w_state_next = ST_UPDATE;
            ST_UPDATE:  w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    // Conversion datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_leds     <= '1;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.load) begin
                        r_bin  <= bus.value;
                        r_bcd  <= '0;
                        r_cnt  <= CNT_W'(BIN_WIDTH - 1);
                        r_busy <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    r_bin <= w_bin_next;
                    r_bcd <= w_bcd_next;
                    r_cnt <= r_cnt - 1'b1;
                    if (w_cnt_tc) begin
                        r_leds     <= w_leds;
                        r_overflow <= w_ovf;
                        r_done     <= 1'b1;
                    end
                end
                ST_UPDATE: begin
                    r_busy <= 1'b0;
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;
    assign bus.leds     = r_leds;
endmodule
